// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle control sequencer: FSM states, opcodes,
// ALU and register-file write-source selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_STORE  = 4'd4,
    ST_LOAD_A = 4'd5,
    ST_LOAD_B = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_JMP    = 4'd9,
    ST_BRZ_A  = 4'd10,
    ST_BRZ_B  = 4'd11,
    ST_HALT   = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    OP_NOOP  = 3'd0,
    OP_STORE = 3'd1,
    OP_LOAD  = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_HALT  = 3'd5,
    OP_JMP   = 3'd6,
    OP_BRZ   = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ALU_PASS_A = 2'd0,
    ALU_ADD    = 2'd1,
    ALU_SUB    = 2'd2
  } alu_sel_t;

  typedef enum logic [1:0] {
    RF_SEL_ALU = 2'd0,
    RF_SEL_MEM = 2'd1
  } rf_sel_t;

  // First execute state entered from DECODE for a legal opcode.
  function automatic state_t op_entry_state(input op_t op);
    state_t st;
    case (op)
      OP_NOOP:  st = ST_NOOP;
      OP_STORE: st = ST_STORE;
      OP_LOAD:  st = ST_LOAD_A;
      OP_ADD:   st = ST_ADD;
      OP_SUB:   st = ST_SUB;
      OP_HALT:  st = ST_HALT;
      OP_JMP:   st = ST_JMP;
      OP_BRZ:   st = ST_BRZ_A;
      default:  st = ST_NOOP;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_pc.sv
// Program counter: load has priority over increment; increment wraps modulo 2^PC_W.
module ctrl_pc #(
  parameter int PC_W = 7
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_val_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer with ready-handshaked instruction and
// data memories. Outputs are registered from the next state, so they track state_q.
module ctrl_sequencer #(
  parameter int IR_W   = 16,
  parameter int OP_W   = 4,
  parameter int RF_A_W = 4,
  parameter int D_A_W  = 8,
  parameter int PC_W   = 7
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic [IR_W-1:0]   IR_in,
  input  logic              I_ready,
  input  logic              D_ready,
  input  logic              ALU_zero,
  output logic [PC_W-1:0]   PC_out,
  output logic              I_req,
  output logic [D_A_W-1:0]  D_addr,
  output logic              D_rd,
  output logic              D_wr,
  output logic [RF_A_W-1:0] RF_W_addr,
  output logic              RF_W_en,
  output logic [1:0]        RF_W_sel,
  output logic [RF_A_W-1:0] RF_Ra_addr,
  output logic [RF_A_W-1:0] RF_Rb_addr,
  output logic              RF_Ra_rd,
  output logic              RF_Rb_rd,
  output logic [1:0]        ALU_sel,
  output logic              Halted,
  output logic              Illegal,
  output logic [3:0]        State
);

  import ctrl_pkg::*;

  state_t            state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              illegal_q, illegal_d;
  logic              pc_inc_s, pc_load_s;
  logic [OP_W-1:0]   opcode_s;

  logic              i_req_q, i_req_d;
  logic [D_A_W-1:0]  d_addr_q, d_addr_d;
  logic              d_rd_q, d_rd_d, d_wr_q, d_wr_d;
  logic [RF_A_W-1:0] w_addr_q, w_addr_d, ra_addr_q, ra_addr_d, rb_addr_q, rb_addr_d;
  logic              w_en_q, w_en_d, ra_rd_q, ra_rd_d, rb_rd_q, rb_rd_d;
  rf_sel_t           w_sel_q, w_sel_d;
  alu_sel_t          alu_sel_q, alu_sel_d;
  logic              halted_q, halted_d;

  assign opcode_s = ir_q[IR_W-1 -: OP_W];

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    pc_inc_s  = 1'b0;
    pc_load_s = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (Run) state_d = ST_FETCH;
        else     state_d = ST_INIT;
      end
      ST_FETCH: begin
        if (I_ready) begin
          ir_d     = IR_in;
          pc_inc_s = 1'b1;
          state_d  = ST_DECODE;
        end else begin
          state_d  = ST_FETCH;
        end
      end
      ST_DECODE: begin
        // Opcodes outside 0..7 raise the sticky flag and retire as NOOP.
        if (opcode_s > OP_W'(7)) begin
          illegal_d = 1'b1;
          state_d   = ST_NOOP;
        end else begin
          state_d   = op_entry_state(op_t'(opcode_s[2:0]));
        end
      end
      ST_NOOP, ST_ADD, ST_SUB, ST_LOAD_B: state_d = ST_FETCH;
      ST_JMP: begin
        pc_load_s = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_STORE: begin
        if (D_ready) state_d = ST_FETCH;
        else         state_d = ST_STORE;
      end
      ST_LOAD_A: begin
        if (D_ready) state_d = ST_LOAD_B;
        else         state_d = ST_LOAD_A;
      end
      ST_BRZ_A: state_d = ST_BRZ_B;
      ST_BRZ_B: begin
        pc_load_s = ALU_zero;
        state_d   = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_INIT;
    endcase
  end

  // Output decode of the upcoming state/IR; registering it gives Moore outputs of state_q/ir_q.
  always_comb begin
    i_req_d   = 1'b0;
    d_addr_d  = '0;
    d_rd_d    = 1'b0;
    d_wr_d    = 1'b0;
    w_addr_d  = '0;
    w_en_d    = 1'b0;
    w_sel_d   = RF_SEL_ALU;
    ra_addr_d = '0;
    rb_addr_d = '0;
    ra_rd_d   = 1'b0;
    rb_rd_d   = 1'b0;
    alu_sel_d = ALU_PASS_A;
    halted_d  = 1'b0;
    case (state_d)
      ST_FETCH: i_req_d = 1'b1;
      ST_STORE: begin
        ra_rd_d   = 1'b1;
        ra_addr_d = ir_d[IR_W-OP_W-1 -: RF_A_W];
        d_wr_d    = 1'b1;
        d_addr_d  = ir_d[D_A_W-1:0];
      end
      ST_LOAD_A: begin
        d_rd_d   = 1'b1;
        d_addr_d = ir_d[D_A_W-1:0];
      end
      ST_LOAD_B: begin
        w_en_d   = 1'b1;
        w_sel_d  = RF_SEL_MEM;
        w_addr_d = ir_d[IR_W-OP_W-1 -: RF_A_W];
      end
      ST_ADD, ST_SUB: begin
        ra_rd_d   = 1'b1;
        rb_rd_d   = 1'b1;
        ra_addr_d = ir_d[IR_W-OP_W-RF_A_W-1 -: RF_A_W];
        rb_addr_d = ir_d[IR_W-OP_W-2*RF_A_W-1 -: RF_A_W];
        w_en_d    = 1'b1;
        w_addr_d  = ir_d[IR_W-OP_W-1 -: RF_A_W];
        alu_sel_d = (state_d == ST_ADD) ? ALU_ADD : ALU_SUB;
      end
      ST_BRZ_A: begin
        ra_rd_d   = 1'b1;
        ra_addr_d = ir_d[IR_W-OP_W-1 -: RF_A_W];
        alu_sel_d = ALU_PASS_A;
      end
      ST_HALT: halted_d = 1'b1;
      default: i_req_d = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_INIT;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      i_req_q   <= 1'b0;
      d_addr_q  <= '0;
      d_rd_q    <= 1'b0;
      d_wr_q    <= 1'b0;
      w_addr_q  <= '0;
      w_en_q    <= 1'b0;
      w_sel_q   <= RF_SEL_ALU;
      ra_addr_q <= '0;
      rb_addr_q <= '0;
      ra_rd_q   <= 1'b0;
      rb_rd_q   <= 1'b0;
      alu_sel_q <= ALU_PASS_A;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      i_req_q   <= i_req_d;
      d_addr_q  <= d_addr_d;
      d_rd_q    <= d_rd_d;
      d_wr_q    <= d_wr_d;
      w_addr_q  <= w_addr_d;
      w_en_q    <= w_en_d;
      w_sel_q   <= w_sel_d;
      ra_addr_q <= ra_addr_d;
      rb_addr_q <= rb_addr_d;
      ra_rd_q   <= ra_rd_d;
      rb_rd_q   <= rb_rd_d;
      alu_sel_q <= alu_sel_d;
      halted_q  <= halted_d;
    end
  end

  ctrl_pc #(.PC_W(PC_W)) u_pc (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .inc_i      (pc_inc_s),
    .load_i     (pc_load_s),
    .load_val_i (ir_q[PC_W-1:0]),
    .pc_o       (PC_out)
  );

  assign I_req      = i_req_q;
  assign D_addr     = d_addr_q;
  assign D_rd       = d_rd_q;
  assign D_wr       = d_wr_q;
  assign RF_W_addr  = w_addr_q;
  assign RF_W_en    = w_en_q;
  assign RF_W_sel   = w_sel_q;
  assign RF_Ra_addr = ra_addr_q;
  assign RF_Rb_addr = rb_addr_q;
  assign RF_Ra_rd   = ra_rd_q;
  assign RF_Rb_rd   = rb_rd_q;
  assign ALU_sel    = alu_sel_q;
  assign Halted     = halted_q;
  assign Illegal    = illegal_q;
  assign State      = state_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: ROM is a bench array addressed by PC_out,
// every expectation is a hand-computed constant.
module tb_ctrl_sequencer;

  logic        Clk, Reset, Run, I_ready, D_ready, ALU_zero;
  logic [15:0] IR_in;
  logic [6:0]  PC_out;
  logic        I_req, D_rd, D_wr, RF_W_en, RF_Ra_rd, RF_Rb_rd, Halted, Illegal;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
  logic [1:0]  RF_W_sel, ALU_sel;
  logic [15:0] rom [0:127];
  logic [42:0] all_outs;
  int          checks, errors;

  ctrl_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .IR_in(IR_in), .I_ready(I_ready),
    .D_ready(D_ready), .ALU_zero(ALU_zero), .PC_out(PC_out), .I_req(I_req),
    .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr), .RF_W_addr(RF_W_addr),
    .RF_W_en(RF_W_en), .RF_W_sel(RF_W_sel), .RF_Ra_addr(RF_Ra_addr),
    .RF_Rb_addr(RF_Rb_addr), .RF_Ra_rd(RF_Ra_rd), .RF_Rb_rd(RF_Rb_rd),
    .ALU_sel(ALU_sel), .Halted(Halted), .Illegal(Illegal), .State(State)
  );

  assign IR_in = rom[PC_out];
  assign all_outs = {PC_out, I_req, D_addr, D_rd, D_wr, RF_W_addr, RF_W_en, RF_W_sel,
                     RF_Ra_addr, RF_Rb_addr, RF_Ra_rd, RF_Rb_rd, ALU_sel, Halted,
                     Illegal, State};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    clear_rom();
    Reset = 1'b1; Run = 1'b1; I_ready = 1'b1; D_ready = 1'b0; ALU_zero = 1'b0;
    tick();
    tick();
    checks++;
    if (all_outs !== 43'd0) begin
      errors++; $display("FAIL reset_outs got %h exp 0", all_outs);
    end
    Reset = 1'b0;
    tick();
    checks++;
    if ({State, I_req, PC_out} !== {4'd1, 1'b1, 7'd0}) begin
      errors++; $display("FAIL rst_fetch got st=%0d ireq=%b pc=%0d exp st=1 ireq=1 pc=0", State, I_req, PC_out);
    end
    tick();
    checks++;
    if ({State, I_req, PC_out} !== {4'd2, 1'b0, 7'd1}) begin
      errors++; $display("FAIL rst_decode got st=%0d ireq=%b pc=%0d exp st=2 ireq=0 pc=1", State, I_req, PC_out);
    end
  endtask

  task automatic test_load;
    int rd_cycles;
    clear_rom();
    rom[0] = 16'h2320;
    Run = 1'b1; I_ready = 1'b1; D_ready = 1'b0;
    do_reset();
    tick();
    tick();
    rd_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (D_rd === 1'b1) rd_cycles++;
      checks++;
      if ({State, D_rd, D_addr, RF_W_en} !== {4'd5, 1'b1, 8'h20, 1'b0}) begin
        errors++; $display("FAIL load_a cyc%0d got st=%0d rd=%b addr=%h wen=%b exp st=5 rd=1 addr=20 wen=0", i, State, D_rd, D_addr, RF_W_en);
      end
    end
    D_ready = 1'b1;
    tick();
    D_ready = 1'b0;
    checks++;
    if (rd_cycles !== 4) begin
      errors++; $display("FAIL load_rd_len got %0d exp 4", rd_cycles);
    end
    checks++;
    if ({State, D_rd, RF_W_en, RF_W_addr, RF_W_sel} !== {4'd6, 1'b0, 1'b1, 4'd3, 2'd1}) begin
      errors++; $display("FAIL load_b got st=%0d rd=%b wen=%b wa=%0d ws=%0d exp st=6 rd=0 wen=1 wa=3 ws=1", State, D_rd, RF_W_en, RF_W_addr, RF_W_sel);
    end
    tick();
    checks++;
    if ({State, RF_W_en, PC_out} !== {4'd1, 1'b0, 7'd1}) begin
      errors++; $display("FAIL load_done got st=%0d wen=%b pc=%0d exp st=1 wen=0 pc=1", State, RF_W_en, PC_out);
    end
  endtask

  task automatic test_alu;
    clear_rom();
    rom[0] = 16'h3123;
    rom[1] = 16'h4456;
    do_reset();
    tick();
    tick();
    tick();
    checks++;
    if ({State, ALU_sel, RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_W_en, RF_W_sel, RF_Ra_rd, RF_Rb_rd}
        !== {4'd7, 2'd1, 4'd2, 4'd3, 4'd1, 1'b1, 2'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL add got st=%0d alu=%0d ra=%0d rb=%0d wa=%0d wen=%b exp st=7 alu=1 ra=2 rb=3 wa=1 wen=1", State, ALU_sel, RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_W_en);
    end
    tick();
    checks++;
    if ({State, RF_W_en, PC_out} !== {4'd1, 1'b0, 7'd1}) begin
      errors++; $display("FAIL add_cpi got st=%0d wen=%b pc=%0d exp st=1 wen=0 pc=1", State, RF_W_en, PC_out);
    end
    tick();
    tick();
    checks++;
    if ({State, ALU_sel, RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_W_en}
        !== {4'd8, 2'd2, 4'd5, 4'd6, 4'd4, 1'b1}) begin
      errors++; $display("FAIL sub got st=%0d alu=%0d ra=%0d rb=%0d wa=%0d wen=%b exp st=8 alu=2 ra=5 rb=6 wa=4 wen=1", State, ALU_sel, RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_W_en);
    end
  endtask

  task automatic test_branch;
    clear_rom();
    rom[0] = 16'h7205;
    rom[5] = 16'h7209;
    rom[6] = 16'h607F;
    ALU_zero = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    checks++;
    if ({State, RF_Ra_rd, RF_Ra_addr, ALU_sel, RF_W_en} !== {4'd10, 1'b1, 4'd2, 2'd0, 1'b0}) begin
      errors++; $display("FAIL brz_a got st=%0d rard=%b ra=%0d alu=%0d exp st=10 rard=1 ra=2 alu=0", State, RF_Ra_rd, RF_Ra_addr, ALU_sel);
    end
    tick();
    tick();
    checks++;
    if ({State, PC_out} !== {4'd1, 7'd5}) begin
      errors++; $display("FAIL brz_taken got st=%0d pc=%0d exp st=1 pc=5", State, PC_out);
    end
    ALU_zero = 1'b0;
    tick();
    tick();
    tick();
    tick();
    checks++;
    if ({State, PC_out} !== {4'd1, 7'd6}) begin
      errors++; $display("FAIL brz_not_taken got st=%0d pc=%0d exp st=1 pc=6", State, PC_out);
    end
    tick();
    tick();
    tick();
    checks++;
    if ({State, PC_out} !== {4'd1, 7'h7F}) begin
      errors++; $display("FAIL jmp got st=%0d pc=%h exp st=1 pc=7f", State, PC_out);
    end
    tick();
    checks++;
    if ({State, PC_out} !== {4'd2, 7'd0}) begin
      errors++; $display("FAIL pc_wrap got st=%0d pc=%h exp st=2 pc=0", State, PC_out);
    end
  endtask

  task automatic test_illegal_halt;
    int bad;
    clear_rom();
    rom[0] = 16'hF000;
    rom[2] = 16'h5000;
    do_reset();
    tick();
    tick();
    tick();
    checks++;
    if ({State, Illegal} !== {4'd3, 1'b1}) begin
      errors++; $display("FAIL illegal_set got st=%0d ill=%b exp st=3 ill=1", State, Illegal);
    end
    tick();
    tick();
    tick();
    tick();
    tick();
    tick();
    checks++;
    if ({State, Halted, Illegal, PC_out} !== {4'd12, 1'b1, 1'b1, 7'd3}) begin
      errors++; $display("FAIL halt_entry got st=%0d h=%b ill=%b pc=%0d exp st=12 h=1 ill=1 pc=3", State, Halted, Illegal, PC_out);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      Run = ~Run;
      tick();
      if ({State, Halted, I_req, PC_out} !== {4'd12, 1'b1, 1'b0, 7'd3}) bad++;
    end
    Run = 1'b1;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL halt_hold got %0d bad cycles exp 0", bad);
    end
  endtask

  task automatic test_zero_wait;
    clear_rom();
    rom[0] = 16'h1340;
    rom[1] = 16'h2520;
    rom[2] = 16'h5000;
    I_ready = 1'b0; D_ready = 1'b1;
    do_reset();
    tick();
    tick();
    checks++;
    if ({State, I_req, PC_out} !== {4'd1, 1'b1, 7'd0}) begin
      errors++; $display("FAIL fetch_wait got st=%0d ireq=%b pc=%0d exp st=1 ireq=1 pc=0", State, I_req, PC_out);
    end
    I_ready = 1'b1;
    Run = 1'b0;
    tick();
    tick();
    checks++;
    if ({State, D_wr, D_addr, RF_Ra_rd, RF_Ra_addr} !== {4'd4, 1'b1, 8'h40, 1'b1, 4'd3}) begin
      errors++; $display("FAIL store got st=%0d wr=%b addr=%h rard=%b ra=%0d exp st=4 wr=1 addr=40 rard=1 ra=3", State, D_wr, D_addr, RF_Ra_rd, RF_Ra_addr);
    end
    tick();
    checks++;
    if ({State, D_wr, PC_out} !== {4'd1, 1'b0, 7'd1}) begin
      errors++; $display("FAIL store_zw got st=%0d wr=%b pc=%0d exp st=1 wr=0 pc=1", State, D_wr, PC_out);
    end
    tick();
    tick();
    tick();
    checks++;
    if ({State, RF_W_en, RF_W_addr, RF_W_sel} !== {4'd6, 1'b1, 4'd5, 2'd1}) begin
      errors++; $display("FAIL load_zw got st=%0d wen=%b wa=%0d ws=%0d exp st=6 wen=1 wa=5 ws=1", State, RF_W_en, RF_W_addr, RF_W_sel);
    end
    Run = 1'b1;
  endtask

  task automatic test_reset_mid_store;
    clear_rom();
    rom[0] = 16'h1340;
    D_ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    checks++;
    if ({State, D_wr, PC_out} !== {4'd4, 1'b1, 7'd1}) begin
      errors++; $display("FAIL store_pre got st=%0d wr=%b pc=%0d exp st=4 wr=1 pc=1", State, D_wr, PC_out);
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({D_wr, State, PC_out} !== {1'b0, 4'd0, 7'd0}) begin
      errors++; $display("FAIL store_reset got wr=%b st=%0d pc=%0d exp wr=0 st=0 pc=0", D_wr, State, PC_out);
    end
    checks++;
    if (all_outs !== 43'd0) begin
      errors++; $display("FAIL store_reset_outs got %h exp 0", all_outs);
    end
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b1; Run = 1'b0; I_ready = 1'b0; D_ready = 1'b0; ALU_zero = 1'b0;
    clear_rom();
    test_reset();
    test_load();
    test_alu();
    test_branch();
    test_illegal_halt();
    test_zero_wait();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
